// File: rtl/display_bcd_mux.sv
// Two-digit multiplexed common-anode seven-segment driver with a decimal-point flash after each counter wrap.
// Optional build macro LEADING_ZERO_BLANK_EN blanks the tens digit when it is zero.
module display_bcd_mux #(
    parameter int REFRESH_DIV = 50000,
    parameter int DP_HOLD     = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] bcd_in,
    input  logic       tick_in,
    output logic [3:0] an,
    output logic [7:0] sseg
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DP_W  = (DP_HOLD > 0) ? $clog2(DP_HOLD + 1) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DP_W-1:0]  DP_LOAD  = DP_W'(DP_HOLD);

    logic [DIV_W-1:0] div_cnt_r, div_cnt_nxt_s;
    logic             idx_r, idx_nxt_s;
    logic [7:0]       shadow_r, shadow_nxt_s;
    logic [DP_W-1:0]  dp_cnt_r, dp_cnt_nxt_s;
    logic             slot_end_s, frame_end_s;
    logic [3:0]       digit_s;
    logic             dp_n_s;
    logic [3:0]       an_nxt_s;
    logic [7:0]       sseg_nxt_s;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h06;
        endcase
        return seg;
    endfunction

    assign slot_end_s  = (div_cnt_r == DIV_LAST);
    assign frame_end_s = slot_end_s && idx_r;

    // Next-state for divider, scan index, shadow digits and dp timer
    always_comb begin
        div_cnt_nxt_s = div_cnt_r;
        idx_nxt_s     = idx_r;
        shadow_nxt_s  = shadow_r;
        dp_cnt_nxt_s  = dp_cnt_r;
        if (slot_end_s) begin
            div_cnt_nxt_s = {DIV_W{1'b0}};
            idx_nxt_s     = ~idx_r;
        end else begin
            div_cnt_nxt_s = div_cnt_r + DIV_W'(1);
            idx_nxt_s     = idx_r;
        end
        // Shadow only moves between frames so both digits always come from one sample
        if (frame_end_s) begin
            shadow_nxt_s = bcd_in;
        end else begin
            shadow_nxt_s = shadow_r;
        end
        if (tick_in) begin
            dp_cnt_nxt_s = DP_LOAD;
        end else if (frame_end_s && (dp_cnt_r != {DP_W{1'b0}})) begin
            dp_cnt_nxt_s = dp_cnt_r - DP_W'(1);
        end else begin
            dp_cnt_nxt_s = dp_cnt_r;
        end
    end

    // Scan state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_r <= {DIV_W{1'b0}};
            idx_r     <= 1'b0;
            shadow_r  <= 8'h00;
            dp_cnt_r  <= {DP_W{1'b0}};
        end else begin
            div_cnt_r <= div_cnt_nxt_s;
            idx_r     <= idx_nxt_s;
            shadow_r  <= shadow_nxt_s;
            dp_cnt_r  <= dp_cnt_nxt_s;
        end
    end

    // Anode and segment pattern for the digit currently selected
    always_comb begin
        digit_s    = idx_r ? shadow_r[7:4] : shadow_r[3:0];
        dp_n_s     = (!idx_r && (dp_cnt_r != {DP_W{1'b0}})) ? 1'b0 : 1'b1;
        an_nxt_s   = idx_r ? 4'b1101 : 4'b1110;
        sseg_nxt_s = {dp_n_s, seg_decode(digit_s)};
`ifdef LEADING_ZERO_BLANK_EN
        if (idx_r && (shadow_r[7:4] == 4'h0)) begin
            sseg_nxt_s = 8'hFF;
        end else begin
            sseg_nxt_s = {dp_n_s, seg_decode(digit_s)};
        end
`endif
    end

    // Registered display outputs, blank while in reset
    always_ff @(posedge clk) begin
        if (reset) begin
            an   <= 4'b1111;
            sseg <= 8'hFF;
        end else begin
            an   <= an_nxt_s;
            sseg <= sseg_nxt_s;
        end
    end

endmodule

// File: tb/tb_display_bcd_mux.sv
// Self-checking bench for display_bcd_mux: per-cycle scoreboard against a time-based model,
// a table of digit patterns, and hand-written reset / dp-flash sequences.
module tb_display_bcd_mux;

    localparam int R = 4;
    localparam int H = 3;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] TENS_ZERO = 8'hFF;
`else
    localparam logic [7:0] TENS_ZERO = 8'hC0;
`endif

    typedef struct {
        logic [7:0] bcd;
        logic [7:0] units;
        logic [7:0] tens;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] bcd_in;
    logic       tick_in;
    logic [3:0] an;
    logic [7:0] sseg;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_q [$];
    int          m_t;
    logic [7:0]  m_shadow;
    int          m_dp;
    logic [6:0]  dec_tab [16];

    int         lit_cnt;
    int         early_cnt;
    logic [7:0] last_units;
    logic [7:0] last_tens;
    vec_t       vecs [6];

    display_bcd_mux #(.REFRESH_DIV(R), .DP_HOLD(H)) dut (
        .clk     (clk),
        .reset   (reset),
        .bcd_in  (bcd_in),
        .tick_in (tick_in),
        .an      (an),
        .sseg    (sseg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (time %0t)", name, act, exp, $time);
        end
    endtask

    // Expected {an, sseg} from model state: slot position derived from cycles since reset
    function automatic logic [11:0] model_out();
        logic       idx;
        logic [3:0] nib;
        logic       dp_n;
        idx  = ((m_t / R) % 2) == 1;
        nib  = idx ? m_shadow[7:4] : m_shadow[3:0];
        dp_n = !(!idx && (m_dp != 0));
`ifdef LEADING_ZERO_BLANK_EN
        if (idx && (m_shadow[7:4] == 4'h0)) return {4'b1101, 8'hFF};
`endif
        return {(idx ? 4'b1101 : 4'b1110), dp_n, dec_tab[nib]};
    endfunction

    task automatic step(input logic r, input logic [7:0] b, input logic t);
        logic [11:0] want;
        logic        fb;
        reset   = r;
        bcd_in  = b;
        tick_in = t;
        if (r) exp_q.push_back({4'b1111, 8'hFF});
        else   exp_q.push_back(model_out());
        if (r) begin
            m_t = 0; m_shadow = 8'h00; m_dp = 0;
        end else begin
            fb = ((m_t % (2 * R)) == (2 * R - 1));
            if (fb) m_shadow = b;
            if (t) m_dp = H;
            else if (fb && m_dp > 0) m_dp = m_dp - 1;
            m_t++;
        end
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        check("scan", {an, sseg}, want);
        if (an == 4'b1110) begin
            last_units = sseg;
            if (!sseg[7]) lit_cnt++;
        end else if (an == 4'b1101) begin
            last_tens = sseg;
        end
        if (sseg == 8'hF8 || sseg == 8'h99) early_cnt++;
    endtask

    // Idle until the next step falls on a frame boundary
    task automatic run_to_fb(input logic [7:0] b);
        for (int k = 0; k < 2 * R; k++) begin
            if ((m_t % (2 * R)) == (2 * R - 1)) break;
            step(1'b0, b, 1'b0);
        end
    endtask

    initial begin
        dec_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06};
        vecs[0] = '{8'h47, 8'hF8, 8'h99};
        vecs[1] = '{8'hA3, 8'hB0, 8'h86};
        vecs[2] = '{8'h05, 8'h92, TENS_ZERO};
        vecs[3] = '{8'h98, 8'h80, 8'h90};
        vecs[4] = '{8'h1F, 8'h86, 8'hF9};
        vecs[5] = '{8'h62, 8'hA4, 8'h82};
        reset = 1'b1; bcd_in = 8'h00; tick_in = 1'b0;
        m_t = 0; m_shadow = 8'h00; m_dp = 0;
        lit_cnt = 0; early_cnt = 0; last_units = 8'h00; last_tens = 8'h00;

        // Reset held three cycles; the sample after the last one is the first cycle after release
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 8'h00, 1'b0);
            check("reset_blank", {an, sseg}, {4'b1111, 8'hFF});
        end
        step(1'b0, 8'h00, 1'b0);
        check("reset_first_digit", {an, sseg}, {4'b1110, 8'hC0});

        // A new value must not appear before the next frame boundary
        run_to_fb(8'h00);
        step(1'b0, 8'h00, 1'b0);
        early_cnt = 0;
        for (int k = 0; k < 2 * R; k++) step(1'b0, 8'h47, 1'b0);
        check("no_early_show", 12'(early_cnt), 12'd0);

        // Digit pattern table
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 6 * R; k++) step(1'b0, vecs[i].bcd, 1'b0);
            check("vec_units", {4'h0, last_units}, {4'h0, vecs[i].units});
            check("vec_tens",  {4'h0, last_tens},  {4'h0, vecs[i].tens});
        end

        // Single tick: dp lit for H full units slots
        run_to_fb(8'h00);
        lit_cnt = 0;
        step(1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 12 * R; k++) step(1'b0, 8'h00, 1'b0);
        check("dp_single", 12'(lit_cnt), 12'(H * R));

        // Second tick one frame later restarts the hold
        run_to_fb(8'h00);
        lit_cnt = 0;
        step(1'b0, 8'h00, 1'b1);
        run_to_fb(8'h00);
        step(1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 12 * R; k++) step(1'b0, 8'h00, 1'b0);
        check("dp_retrigger", 12'(lit_cnt), 12'((H + 1) * R));

        // Reset during a tens slot with the dp timer running and a tick present
        run_to_fb(8'h00);
        step(1'b0, 8'h00, 1'b1);
        for (int k = 0; k < R + 1; k++) step(1'b0, 8'h00, 1'b0);
        check("pre_reset_tens", {8'h00, an}, {8'h00, 4'b1101});
        step(1'b1, 8'h00, 1'b1);
        check("midscan_reset", {an, sseg}, {4'b1111, 8'hFF});
        lit_cnt = 0;
        step(1'b0, 8'h00, 1'b0);
        check("post_reset_units", {an, sseg}, {4'b1110, 8'hC0});
        for (int k = 0; k < 4 * R; k++) step(1'b0, 8'h00, 1'b0);
        check("post_reset_dp_off", 12'(lit_cnt), 12'd0);
        check("post_reset_tens", {4'h0, last_tens}, {4'h0, TENS_ZERO});
        check("post_reset_units_val", {4'h0, last_units}, {4'h0, 8'hC0});

        // Random traffic against the scoreboard, including ticks mid-slot and rare resets
        for (int k = 0; k < 400; k++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            step(($urandom_range(0, 99) == 0), b, ($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_bcd_mux.md
# display_bcd_mux

Two-digit multiplexed seven-segment driver that sits directly downstream of the two-digit BCD counter. It consumes the counter's packed BCD value (`q`) and its `max_tick` pulse. It time-multiplexes the two digits onto a common-anode 4-digit display with active-low anodes and segments. It also flashes the decimal point for a programmable time after each counter wrap.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles per digit slot (1 ms at 50 MHz); minimum 2.
- `DP_HOLD`, default 250: frames the decimal point stays lit after a tick (frame = 2 digit slots); minimum 1.
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `bcd_in` in 8: packed BCD; [3:0] units, [7:4] tens. Driven from counter `q`.
- `tick_in` in 1: 1-cycle pulse, driven from counter `max_tick`.
- `an` out 4: anode enables, active low; [0] units, [1] tens, [3:2] always 1.
- `sseg` out 8: segments, active low; [7]=dp, [6:0]=g f e d c b a.

## Operation
- Divider `div_cnt` counts 0..REFRESH_DIV-1 and wraps. The cycle with `div_cnt==REFRESH_DIV-1` is a slot boundary.
- Scan index `idx` (0 = units, 1 = tens) toggles at every slot boundary.
- A frame boundary is a slot boundary at which `idx==1`, i.e. idx wraps 1->0.
- Shadow register `shadow[7:0]` loads `bcd_in` only at frame boundaries. This prevents tearing between digits.
- Digit decode (active-low, dp bit excluded, 7-bit `sseg[6:0]`):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Any nibble 10..15 displays "E" (06).
- DP timer `dp_cnt`, width ceil(log2(DP_HOLD+1)):
  - `tick_in`=1 loads DP_HOLD; this reloads even when already nonzero.
  - Otherwise `dp_cnt` decrements by 1 at each frame boundary while it is nonzero; it never goes below 0.
  - If `tick_in` and a frame boundary coincide, the load wins.
- `sseg[7]`=0 only when `idx==0` and `dp_cnt!=0`; otherwise 1.
- `an`: `idx==0` -> 4'b1110, `idx==1` -> 4'b1101.
- Reset values: `div_cnt`=0, `idx`=0, `shadow`=8'h00, `dp_cnt`=0, `an`=4'b1111, `sseg`=8'hFF.
- `reset` asserted mid-scan forces all of the above on the next edge, regardless of `tick_in`.

## Timing
- `an` and `sseg` are registered. They reflect `idx`, `shadow` and `dp_cnt` as held during the previous cycle, a one-cycle output latency.
- First cycle after reset deasserts: outputs still hold their reset values (blank).
- Second cycle after reset deasserts: `an`=1110, `sseg`=8'hC0 (units "0", dp off).
- Each digit is driven for exactly REFRESH_DIV cycles. `an` changes one cycle after the slot-boundary edge.
- A new `bcd_in` becomes visible on the units digit between 1 and 2·REFRESH_DIV+1 cycles after it is applied.
- After `tick_in`, the dp is first lit on the next units slot. It is then lit in DP_HOLD consecutive units slots, counting a units slot already in progress when the tick arrives.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - When `idx==1` and `shadow[7:4]==0`, `sseg`=8'hFF and `an`=4'b1101.
  - The units digit is never blanked.
- `LEADING_ZERO_BLANK_EN` undefined: the tens digit always shows its decoded value, including "0".

## Test plan
All scenarios use REFRESH_DIV=4 and DP_HOLD=3.

- **Reset state:** hold reset 3 cycles, then release.
  - -> During reset and on the first cycle after it: `an`=1111, `sseg`=FF.
  - -> Next cycle: `an`=1110, `sseg`=C0.
- **Scan and capture:** `bcd_in`=8'h47 applied at idle.
  - -> After the next frame boundary, alternating 4-cycle slots: `an`=1110/`sseg`=F8, then `an`=1101/`sseg`=99.
  - -> The value is not shown before that boundary.
- **Invalid BCD:** `bcd_in`=8'hA3.
  - -> Units shows B0 and tens shows 86.
- **DP flash:** pulse `tick_in` once with `bcd_in`=8'h00.
  - -> `sseg[7]`=0 in exactly 3 consecutive units slots, then 1.
  - -> A second tick during the hold extends it to 3 slots from the reload.
- **Leading-zero blanking:** `bcd_in`=8'h05.
  - -> With the macro defined: tens slot `sseg`=FF.
  - -> Without the macro: tens slot `sseg`=C0.
  - -> Units slot `sseg`=92 in both builds.
- **Mid-scan reset:** assert reset during a tens slot with `dp_cnt` nonzero and `tick_in`=1.
  - -> Next edge: `an`=1111, `sseg`=FF.
  - -> After release, the dp stays off and the digits show 00 ("0" only on units with the macro defined).
